// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: state encoding and frame sizing shared by the FIFO UART drain; UART_PARITY_EN adds a parity bit
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_bits(int dsize, int stop_bits);
        return 1 + dsize + PARITY_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/fifo_uart_drain_if.sv
// fifo_uart_drain_if: async FIFO read-port signals between the FIFO and its drain
interface fifo_uart_drain_if #(
    parameter int DSIZE = 8
);
    logic             rinc;
    logic             rempty;
    logic [DSIZE-1:0] rdata;

    modport master (output rinc, input rempty, input rdata);
    modport slave (input rinc, output rempty, output rdata);
endinterface

// File: rtl/baud_gen.sv
// baud_gen: bit-period counter; bit_tick marks the last cycle of each serial bit
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign bit_tick = cnt == CW'(CLKS_PER_BIT - 1);

    // count 0..CLKS_PER_BIT-1 and restart; held at zero while cleared
    always_ff @(posedge clk)
        cnt <= (rst || clr || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops words from the FIFO read port and sends each as a UART frame; UART_PARITY_EN adds even parity
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int DSIZE        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    fifo_uart_drain_if.master fifo,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);
    localparam int BW = DSIZE > 1 ? $clog2(DSIZE) : 1;

    state_t           state, state_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic [DSIZE-1:0] sh, sh_d;
    logic             par, bit_tick, txd_d;

    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE || state == LOAD),
        .bit_tick (bit_tick)
    );

    assign fifo.rinc = state == IDLE && enable && !fifo.rempty && !rst;

`ifdef UART_PARITY_EN
    // parity is taken from the whole word at LOAD because the shift register is consumed during DATA
    always_ff @(posedge clk)
        par <= rst ? 1'b0 : (state == LOAD ? ^fifo.rdata : par);
`else
    assign par = 1'b1;
`endif

    // frame sequencing, one bit period per START/DATA/PARITY/STOP step
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = fifo.rinc ? LOAD : IDLE;
            LOAD:    state_d = START;
            START:   state_d = bit_tick ? DATA : START;
            DATA:    state_d = (bit_tick && bit_cnt == BW'(DSIZE - 1)) ? (PARITY_BITS != 0 ? PARITY : STOP) : DATA;
            PARITY:  state_d = bit_tick ? STOP : PARITY;
            STOP:    state_d = (bit_tick && bit_cnt == BW'(STOP_BITS - 1)) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // next shift word, bit count and line level; txd follows the state being entered so it is registered
    always_comb begin
        sh_d      = state == LOAD ? fifo.rdata : ((state == DATA && bit_tick) ? sh >> 1 : sh);
        bit_cnt_d = state_d != state ? '0 : (bit_tick ? bit_cnt + 1'b1 : bit_cnt);
        txd_d     = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par : 1'b1;
    end

    // state, datapath and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        state   <= rst ? IDLE : state_d;
        bit_cnt <= rst ? '0 : bit_cnt_d;
        sh      <= rst ? '0 : sh_d;
        txd     <= rst | txd_d;
        busy    <= !rst && state_d != IDLE;
        tx_done <= !rst && state == STOP && state_d == IDLE;
    end
endmodule
